// File: rtl/reg_file_wb_pkg.sv
// Shared encodings and widths for the multicycle CPU register-file/write-back slice.
package mini_cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        REG_DST_RT   = 2'b00,
        REG_DST_RD   = 2'b01,
        REG_DST_LINK = 2'b10,
        REG_DST_RSVD = 2'b11
    } reg_dst_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MDR  = 2'b01,
        WB_JAL  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    // A write commits only when neither select carries the reserved code.
    function automatic logic sel_valid(input logic [1:0] dst_sel, input logic [1:0] wb_sel);
        return (dst_sel != 2'b11) && (wb_sel != 2'b11);
    endfunction

endpackage

// File: rtl/reg_file_wb_if.sv
// Control/data bundle between the control unit (master) and the register file (slave).
interface reg_file_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              reg_write;
    logic [1:0]        reg_dst_sel;
    logic [1:0]        wb_sel;
    logic [DATA_W-1:0] ALUout_reg_out;
    logic [DATA_W-1:0] mdr_out;
    logic [DATA_W-1:0] JALreturnPC;
    logic [DATA_W-1:0] A_reg_out;
    logic [DATA_W-1:0] B_reg_out;

    modport master (
        output rs_addr, rt_addr, rd_addr, reg_write, reg_dst_sel, wb_sel,
        output ALUout_reg_out, mdr_out, JALreturnPC,
        input  A_reg_out, B_reg_out
    );

    modport slave (
        input  rs_addr, rt_addr, rd_addr, reg_write, reg_dst_sel, wb_sel,
        input  ALUout_reg_out, mdr_out, JALreturnPC,
        output A_reg_out, B_reg_out
    );
endinterface

// File: rtl/reg_file_wb_regfile_array.sv
// 2-read/1-write register storage; index 0 is hard-wired to zero, SP loads SP_INIT on reset.
module regfile_array #(
    parameter int              DATA_W  = 32,
    parameter int              ADDR_W  = 5,
    parameter int              SP_REG  = 29,
    parameter logic [DATA_W-1:0] SP_INIT = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [NREG];

    // Storage update: reset initialisation wins over the single write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= (i == SP_REG) ? SP_INIT : '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];

endmodule

// File: rtl/reg_file_wb.sv
// Register file plus write-back muxing and A/B operand registers.
// Optional same-cycle forwarding into A/B is enabled by defining REGFILE_BYPASS_EN.
module reg_file_wb #(
    parameter int                DATA_W   = mini_cpu_pkg::DATA_W,
    parameter int                ADDR_W   = mini_cpu_pkg::ADDR_W,
    parameter int                LINK_REG = 31,
    parameter int                SP_REG   = 29,
    parameter logic [DATA_W-1:0] SP_INIT  = '0
) (
    input  logic         clk,
    input  logic         reset,
    reg_file_wb_if.slave bus
);
    import mini_cpu_pkg::*;

    logic [ADDR_W-1:0] w_dst;
    logic [DATA_W-1:0] w_wdata;
    logic              w_we;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [DATA_W-1:0] w_a_next;
    logic [DATA_W-1:0] w_b_next;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;

    // Write-back destination and data selection.
    always_comb begin
        w_dst   = '0;
        w_wdata = '0;
        case (bus.reg_dst_sel)
            REG_DST_RT:   w_dst = bus.rt_addr;
            REG_DST_RD:   w_dst = bus.rd_addr;
            REG_DST_LINK: w_dst = ADDR_W'(LINK_REG);
            default:      w_dst = '0;
        endcase
        case (bus.wb_sel)
            WB_ALU:  w_wdata = bus.ALUout_reg_out;
            WB_MDR:  w_wdata = bus.mdr_out;
            WB_JAL:  w_wdata = bus.JALreturnPC;
            default: w_wdata = '0;
        endcase
    end

    assign w_we = bus.reg_write & sel_valid(bus.reg_dst_sel, bus.wb_sel);

    regfile_array #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .SP_REG  (SP_REG),
        .SP_INIT (SP_INIT)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_we),
        .i_waddr   (w_dst),
        .i_wdata   (w_wdata),
        .i_raddr_a (bus.rs_addr),
        .i_raddr_b (bus.rt_addr),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b)
    );

    // Operand source: forwarded write data or stored contents.
    always_comb begin
        w_a_next = w_rd_a;
        w_b_next = w_rd_b;
`ifdef REGFILE_BYPASS_EN
        if (w_we && (w_dst == bus.rs_addr) && (bus.rs_addr != '0)) begin
            w_a_next = w_wdata;
        end else begin
            w_a_next = w_rd_a;
        end
        if (w_we && (w_dst == bus.rt_addr) && (bus.rt_addr != '0)) begin
            w_b_next = w_wdata;
        end else begin
            w_b_next = w_rd_b;
        end
`else
        w_a_next = w_rd_a;
        w_b_next = w_rd_b;
`endif
    end

    // A/B operand registers capture every cycle outside reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            r_a <= w_a_next;
            r_b <= w_b_next;
        end
    end

    assign bus.A_reg_out = r_a;
    assign bus.B_reg_out = r_b;

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: expected A/B queued at drive time, compared after the edge.
module tb_reg_file_wb;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_regs [32];
    logic [31:0] q_exp_a [$];
    logic [31:0] q_exp_b [$];
    logic [31:0] q_obs_a [$];
    logic [31:0] q_obs_b [$];
    logic [31:0] last_a;
    logic [31:0] last_b;

    reg_file_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file_wb #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .LINK_REG (31),
        .SP_REG   (29),
        .SP_INIT  (32'h0000_7FFC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cycle(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic we, input logic [1:0] dst,
                         input logic [1:0] wb, input logic [31:0] alu,
                         input logic [31:0] mdr, input logic [31:0] jal);
        logic [4:0]  d;
        logic [31:0] wd;
        logic        v;
        logic [31:0] ea;
        logic [31:0] eb;
        reset              = rst;
        bus.rs_addr        = rs;
        bus.rt_addr        = rt;
        bus.rd_addr        = rd;
        bus.reg_write      = we;
        bus.reg_dst_sel    = dst;
        bus.wb_sel         = wb;
        bus.ALUout_reg_out = alu;
        bus.mdr_out        = mdr;
        bus.JALreturnPC    = jal;
        if (rst) begin
            ea = 32'h0;
            eb = 32'h0;
            for (int i = 0; i < 32; i++) m_regs[i] = (i == 29) ? 32'h0000_7FFC : 32'h0;
        end else begin
            v  = we && (dst != 2'b11) && (wb != 2'b11);
            d  = (dst == 2'b00) ? rt : (dst == 2'b01) ? rd : 5'd31;
            wd = (wb == 2'b00) ? alu : (wb == 2'b01) ? mdr : jal;
            ea = (rs == 5'd0) ? 32'h0 : m_regs[rs];
            eb = (rt == 5'd0) ? 32'h0 : m_regs[rt];
`ifdef REGFILE_BYPASS_EN
            if (v && d == rs && rs != 5'd0) ea = wd;
            if (v && d == rt && rt != 5'd0) eb = wd;
`endif
            if (v && d != 5'd0) m_regs[d] = wd;
        end
        q_exp_a.push_back(ea);
        q_exp_b.push_back(eb);
        @(posedge clk);
        #1;
        last_a = bus.A_reg_out;
        last_b = bus.B_reg_out;
        q_obs_a.push_back(last_a);
        q_obs_b.push_back(last_b);
    endtask

    task automatic test_reset();
        logic [31:0] ea, eb, oa, ob;
        cycle(1'b1, 5'd29, 5'd5, 5'd0, 1'b1, 2'b01, 2'b00, 32'h1234_5678, 32'h0, 32'h0);
        cycle(1'b1, 5'd29, 5'd5, 5'd0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
        cycle(1'b0, 5'd29, 5'd5, 5'd0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
        checks++;
        if (last_a !== 32'h0000_7FFC) begin
            errors++;
            $display("FAIL reset_sp A got %h exp %h", last_a, 32'h0000_7FFC);
        end
        for (int i = 0; q_exp_a.size() != 0; i++) begin
            ea = q_exp_a.pop_front(); eb = q_exp_b.pop_front();
            oa = q_obs_a.pop_front(); ob = q_obs_b.pop_front();
            checks += 2;
            if (oa !== ea) begin errors++; $display("FAIL reset A[%0d] got %h exp %h", i, oa, ea); end
            if (ob !== eb) begin errors++; $display("FAIL reset B[%0d] got %h exp %h", i, ob, eb); end
        end
    endtask

    task automatic test_jal_rtype();
        logic [31:0] ea, eb, oa, ob;
        cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 2'b10, 2'b10, 32'h0, 32'h0, 32'h0040_0008);
        cycle(1'b0, 5'd31, 5'd0, 5'd0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
        checks++;
        if (last_a !== 32'h0040_0008) begin
            errors++;
            $display("FAIL jal_link A got %h exp %h", last_a, 32'h0040_0008);
        end
        cycle(1'b0, 5'd0, 5'd0, 5'd8, 1'b1, 2'b01, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0);
        cycle(1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
        checks++;
        if (last_b !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rtype B got %h exp %h", last_b, 32'hDEAD_BEEF);
        end
        cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 2'b00, 2'b01, 32'h0, 32'hCAFE_F00D, 32'h0);
        cycle(1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 2'b01, 2'b01, 32'h0, 32'hA5A5_5A5A, 32'h0);
        cycle(1'b0, 5'd3, 5'd31, 5'd0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
        for (int i = 0; q_exp_a.size() != 0; i++) begin
            ea = q_exp_a.pop_front(); eb = q_exp_b.pop_front();
            oa = q_obs_a.pop_front(); ob = q_obs_b.pop_front();
            checks += 2;
            if (oa !== ea) begin errors++; $display("FAIL wb A[%0d] got %h exp %h", i, oa, ea); end
            if (ob !== eb) begin errors++; $display("FAIL wb B[%0d] got %h exp %h", i, ob, eb); end
        end
    endtask

    task automatic test_zero_reg();
        logic [31:0] ea, eb, oa, ob;
        cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 2'b01, 2'b00, 32'hFFFF_FFFF, 32'h0, 32'h0);
        checks++;
        if (last_a !== 32'h0) begin errors++; $display("FAIL zero_same A got %h exp 0", last_a); end
        cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
        checks++;
        if (last_a !== 32'h0) begin errors++; $display("FAIL zero_next A got %h exp 0", last_a); end
        for (int i = 0; q_exp_a.size() != 0; i++) begin
            ea = q_exp_a.pop_front(); eb = q_exp_b.pop_front();
            oa = q_obs_a.pop_front(); ob = q_obs_b.pop_front();
            checks += 2;
            if (oa !== ea) begin errors++; $display("FAIL zero A[%0d] got %h exp %h", i, oa, ea); end
            if (ob !== eb) begin errors++; $display("FAIL zero B[%0d] got %h exp %h", i, ob, eb); end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] ea, eb, oa, ob;
        logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h2;
`else
        exp_same = 32'h1;
`endif
        cycle(1'b0, 5'd0, 5'd0, 5'd9, 1'b1, 2'b01, 2'b00, 32'h1, 32'h0, 32'h0);
        cycle(1'b0, 5'd0, 5'd9, 5'd9, 1'b1, 2'b01, 2'b00, 32'h2, 32'h0, 32'h0);
        checks++;
        if (last_b !== exp_same) begin
            errors++;
            $display("FAIL bypass_same B got %h exp %h", last_b, exp_same);
        end
        cycle(1'b0, 5'd0, 5'd9, 5'd0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
        checks++;
        if (last_b !== 32'h2) begin errors++; $display("FAIL bypass_next B got %h exp 2", last_b); end
        cycle(1'b0, 5'd9, 5'd0, 5'd9, 1'b1, 2'b01, 2'b01, 32'h0, 32'h3, 32'h0);
        for (int i = 0; q_exp_a.size() != 0; i++) begin
            ea = q_exp_a.pop_front(); eb = q_exp_b.pop_front();
            oa = q_obs_a.pop_front(); ob = q_obs_b.pop_front();
            checks += 2;
            if (oa !== ea) begin errors++; $display("FAIL bypass A[%0d] got %h exp %h", i, oa, ea); end
            if (ob !== eb) begin errors++; $display("FAIL bypass B[%0d] got %h exp %h", i, ob, eb); end
        end
    endtask

    task automatic test_reserved_reset();
        logic [31:0] ea, eb, oa, ob;
        cycle(1'b0, 5'd0, 5'd0, 5'd4, 1'b1, 2'b01, 2'b00, 32'h4444_4444, 32'h0, 32'h0);
        cycle(1'b0, 5'd0, 5'd4, 5'd4, 1'b1, 2'b11, 2'b00, 32'h9999_9999, 32'h0, 32'h0);
        cycle(1'b0, 5'd4, 5'd4, 5'd4, 1'b1, 2'b01, 2'b11, 32'h8888_8888, 32'h0, 32'h0);
        cycle(1'b0, 5'd4, 5'd31, 5'd0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
        checks++;
        if (last_a !== 32'h4444_4444) begin
            errors++;
            $display("FAIL reserved A got %h exp %h", last_a, 32'h4444_4444);
        end
        cycle(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 2'b00, 2'b00, 32'h5555_5555, 32'h0, 32'h0);
        cycle(1'b0, 5'd4, 5'd29, 5'd0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
        checks++;
        if (last_a !== 32'h0) begin errors++; $display("FAIL reset_write A got %h exp 0", last_a); end
        for (int i = 0; q_exp_a.size() != 0; i++) begin
            ea = q_exp_a.pop_front(); eb = q_exp_b.pop_front();
            oa = q_obs_a.pop_front(); ob = q_obs_b.pop_front();
            checks += 2;
            if (oa !== ea) begin errors++; $display("FAIL rsvd A[%0d] got %h exp %h", i, oa, ea); end
            if (ob !== eb) begin errors++; $display("FAIL rsvd B[%0d] got %h exp %h", i, ob, eb); end
        end
    endtask

    task automatic test_random();
        logic [31:0] ea, eb, oa, ob;
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  32'($urandom), 32'($urandom), 32'($urandom));
        end
        for (int r = 0; r < 32; r += 2) begin
            cycle(1'b0, 5'(r), 5'(r + 1), 5'd0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
        end
        for (int i = 0; q_exp_a.size() != 0; i++) begin
            ea = q_exp_a.pop_front(); eb = q_exp_b.pop_front();
            oa = q_obs_a.pop_front(); ob = q_obs_b.pop_front();
            checks += 2;
            if (oa !== ea) begin errors++; $display("FAIL random A[%0d] got %h exp %h", i, oa, ea); end
            if (ob !== eb) begin errors++; $display("FAIL random B[%0d] got %h exp %h", i, ob, eb); end
        end
    endtask

    initial begin
        test_reset();
        test_jal_rtype();
        test_zero_reg();
        test_bypass();
        test_reserved_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
